// File: rtl/truth_table_capture.sv
// Sweeps a 3-input DUT through vectors 0..7, capturing its output as a minterm mask and comparing it to a latched expectation.
// A sweep takes 8*(SETTLE+1) cycles from the accepted start edge to done; start is ignored while a sweep is running.
module truth_table_capture #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] expected_i,
  input  logic       s_i,
  output logic       x_o,
  output logic       y_o,
  output logic       z_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] mask_o,
  output logic       pass_o,
  output logic [2:0] fail_idx_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  logic [1:0] state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] exp_q, exp_d;
  logic [7:0] diff;
  logic [2:0] first_diff;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    exp_d   = exp_q;
    case (state_q)
      RUN: begin
        if (cnt_q == SETTLE_C) begin
          mask_d[idx_q] = s_i;
          cnt_d         = 4'd0;
          // Index stays at 7 in DONE so the last vector remains on the DUT inputs.
          if (idx_q == 3'd7) state_d = DONE;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        if (start_i) begin
          state_d = RUN;
          exp_d   = expected_i;
          mask_d  = 8'h00;
          idx_d   = 3'd0;
          cnt_d   = 4'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      mask_q  <= 8'h00;
      exp_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      exp_q   <= exp_d;
    end
  end

  assign diff = mask_q ^ exp_q;

  always_comb begin
    first_diff = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (diff[k]) first_diff = 3'(k);
    end
  end

  assign {x_o, y_o, z_o} = idx_q;
  assign busy_o     = (state_q == RUN);
  assign done_o     = (state_q == DONE);
  assign mask_o     = mask_q;
  // Verdict outputs are forced low outside DONE so reset and mid-sweep values read as zero.
  assign pass_o     = done_o && (diff == 8'h00);
  assign fail_idx_o = done_o ? first_diff : 3'd0;

endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture: two instances (SETTLE=2 and SETTLE=0), each driven by a
// lookup-table DUT model, checked against a truth-table reference computed from first principles.
module tb_truth_table_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start [2];
  logic [7:0] expv  [2];
  logic       s     [2];
  logic       x [2], y [2], z [2];
  logic       busy [2], done [2], pass [2];
  logic [7:0] mask [2];
  logic [2:0] fidx [2];
  logic [7:0] tbl  [2];

  int checks = 0;
  int errors = 0;

  truth_table_capture #(.SETTLE(2)) u_dut_s2 (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]), .expected_i(expv[0]), .s_i(s[0]),
    .x_o(x[0]), .y_o(y[0]), .z_o(z[0]), .busy_o(busy[0]), .done_o(done[0]),
    .mask_o(mask[0]), .pass_o(pass[0]), .fail_idx_o(fidx[0])
  );

  truth_table_capture #(.SETTLE(0)) u_dut_s0 (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]), .expected_i(expv[1]), .s_i(s[1]),
    .x_o(x[1]), .y_o(y[1]), .z_o(z[1]), .busy_o(busy[1]), .done_o(done[1]),
    .mask_o(mask[1]), .pass_o(pass[1]), .fail_idx_o(fidx[1])
  );

  // The circuit under test responds to its input vector through a lookup table.
  assign s[0] = tbl[0][{x[0], y[0], z[0]}];
  assign s[1] = tbl[1][{x[1], y[1], z[1]}];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Truth table of S = (x + y')' . z' = x' . y . z'
  function automatic logic [7:0] expr_tbl();
    logic [7:0] r;
    logic [2:0] v;
    r = 8'h00;
    for (int k = 0; k < 8; k++) begin
      v    = 3'(k);
      r[k] = !(v[2] || !v[1]) && !v[0];
    end
    return r;
  endfunction

  function automatic logic [2:0] ref_fail(input logic [7:0] m, input logic [7:0] e);
    for (int k = 0; k < 8; k++) begin
      if (m[k] != e[k]) return 3'(k);
    end
    return 3'd0;
  endfunction

  task automatic check_reset_outputs(input int d);
    check("rst_busy", 32'(busy[d]), 32'd0);
    check("rst_done", 32'(done[d]), 32'd0);
    check("rst_xyz",  32'({x[d], y[d], z[d]}), 32'd0);
    check("rst_mask", 32'(mask[d]), 32'd0);
    check("rst_pass", 32'(pass[d]), 32'd0);
    check("rst_fidx", 32'(fidx[d]), 32'd0);
  endtask

  // One full sweep on instance d; optional stray start (with a changed expectation) at hold-cycle restart_at.
  task automatic sweep(input int d, input logic [7:0] e, input logic [7:0] t, input int restart_at);
    int hold;
    int total;
    hold  = (d == 0) ? 3 : 1;
    total = 8 * hold;
    tbl[d]   = t;
    expv[d]  = e;
    start[d] = 1'b1;
    step();
    start[d] = 1'b0;
    check("start_mask", 32'(mask[d]), 32'd0);
    for (int n = 0; n < total; n++) begin
      if (n == restart_at) begin
        start[d] = 1'b1;
        expv[d]  = 8'h00;
      end else begin
        start[d] = 1'b0;
      end
      check("run_busy", 32'(busy[d]), 32'd1);
      check("run_done", 32'(done[d]), 32'd0);
      check("run_xyz",  32'({x[d], y[d], z[d]}), 32'(n / hold));
      step();
    end
    start[d] = 1'b0;
    check("end_done", 32'(done[d]), 32'd1);
    check("end_busy", 32'(busy[d]), 32'd0);
    check("end_xyz",  32'({x[d], y[d], z[d]}), 32'd7);
    check("end_mask", 32'(mask[d]), 32'(t));
    check("end_pass", 32'(pass[d]), 32'(t == e));
    check("end_fidx", 32'(fidx[d]), 32'(ref_fail(t, e)));
  endtask

  initial begin
    logic [7:0] t;
    logic [7:0] e;
    int         d;
    int         ra;
    int         gap;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      expv[i]  = 8'h00;
      tbl[i]   = 8'h00;
    end
    #3;
    check_reset_outputs(0);
    check_reset_outputs(1);
    #10 rst_n = 1'b1;
    repeat (3) step();
    check("idle_busy", 32'(busy[0]), 32'd0);
    check("idle_done", 32'(done[0]), 32'd0);

    // Expression DUT, matching expectation
    sweep(0, 8'h04, expr_tbl(), -1);
    check("expr_mask", 32'(mask[0]), 32'h04);
    check("expr_pass", 32'(pass[0]), 32'd1);
    check("expr_fidx", 32'(fidx[0]), 32'd0);

    // Same DUT, wrong expectation; also a start taken from DONE
    sweep(0, 8'h06, expr_tbl(), -1);
    check("mis_mask", 32'(mask[0]), 32'h04);
    check("mis_pass", 32'(pass[0]), 32'd0);
    check("mis_fidx", 32'(fidx[0]), 32'd1);

    // s tied high with SETTLE=0
    sweep(1, 8'hFF, 8'hFF, -1);
    check("tie_mask", 32'(mask[1]), 32'hFF);
    check("tie_pass", 32'(pass[1]), 32'd1);

    // Stray start mid-sweep with a different expectation
    sweep(0, 8'h04, expr_tbl(), 5);
    check("restart_mask", 32'(mask[0]), 32'h04);
    check("restart_pass", 32'(pass[0]), 32'd1);
    check("restart_fidx", 32'(fidx[0]), 32'd0);

    // Asynchronous reset mid-sweep
    tbl[0]   = expr_tbl();
    expv[0]  = 8'h04;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (10) step();
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs(0);
    #2 rst_n = 1'b1;
    for (int n = 0; n < 30; n++) begin
      step();
      if (n % 10 == 9) begin
        check("abort_done", 32'(done[0]), 32'd0);
        check("abort_busy", 32'(busy[0]), 32'd0);
      end
    end
    sweep(0, 8'h04, expr_tbl(), -1);

    // Randomized sweeps, with stable-result checks in DONE
    repeat (10) begin
      d  = int'($urandom_range(0, 1));
      t  = 8'($urandom);
      e  = ($urandom_range(0, 2) == 0) ? t : 8'($urandom);
      ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, (d == 0) ? 22 : 6)) : -1;
      sweep(d, e, t, ra);
      gap = int'($urandom_range(0, 4));
      expv[d] = 8'($urandom);
      repeat (gap) step();
      check("hold_done", 32'(done[d]), 32'd1);
      check("hold_mask", 32'(mask[d]), 32'(t));
      check("hold_pass", 32'(pass[d]), 32'(t == e));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
